// File: rtl/audio_mixer_nch.sv
// audio_mixer_nch: N-channel volume/mute mixer with master attenuation, saturation and circular buffer write
module audio_mixer_nch #(
  parameter int NUM_CH      = 4,
  parameter int SAMPLE_BITS = 16,
  parameter int VOLUME_BITS = 8,
  parameter int MASTER_BITS = 4,
  parameter int BUF_LEN     = 256
) (
  input  logic                            mclk,
  input  logic                            rst,
  input  logic                            sample_tick,
  input  logic [NUM_CH*SAMPLE_BITS-1:0]   ch_sample,
  input  logic [NUM_CH*VOLUME_BITS-1:0]   ch_vol,
  input  logic [NUM_CH-1:0]               ch_mute,
  input  logic [MASTER_BITS-1:0]          master_atten,
  output logic                            busy,
  output logic [SAMPLE_BITS-1:0]          mix_sample,
  output logic                            mix_valid,
  output logic                            buf_wr_en,
  output logic [$clog2(BUF_LEN)-1:0]      buf_wr_addr,
  output logic [SAMPLE_BITS-1:0]          buf_wr_data,
  output logic                            overrun,
  output logic [15:0]                     clip_count
);
  localparam int SB = SAMPLE_BITS;
  localparam int VB = VOLUME_BITS;
  localparam int PW = SB + VB + 1;
  localparam int AW = SB + $clog2(NUM_CH) + 1;
  localparam int IW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int AB = $clog2(BUF_LEN);
  typedef enum logic [1:0] {IDLE, ACCUM, SCALE} state_t;
  state_t state, state_nx;
  logic [NUM_CH*SB-1:0]   smp_snap;
  logic [NUM_CH*VB-1:0]   vol_snap;
  logic [NUM_CH-1:0]      mute_snap;
  logic [MASTER_BITS-1:0] atten_snap;
  logic [IW-1:0]          ch_idx;
  logic signed [AW-1:0]   acc, term, s;
  logic signed [PW-1:0]   prod;
  logic                   last, clip;
  logic [SB-1:0]          sat;
  assign busy = state != IDLE;
  assign last = ch_idx == IW'(NUM_CH - 1);
  // the product's top SB+1 bits are exactly the floored >>> VB result
  assign prod = PW'($signed(smp_snap[ch_idx*SB +: SB])) * PW'($signed({1'b0, vol_snap[ch_idx*VB +: VB]}));
  assign term = mute_snap[ch_idx] ? '0 : AW'($signed(prod[PW-1:VB]));
  assign s    = acc >>> atten_snap;
  assign clip = !(&s[AW-1:SB-1] || ~|s[AW-1:SB-1]);
  assign sat  = clip ? {s[AW-1], {(SB-1){~s[AW-1]}}} : s[SB-1:0];
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (sample_tick ? ACCUM : IDLE) : state == ACCUM ? (last ? SCALE : ACCUM) : IDLE;
  end
  always_ff @(posedge mclk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge mclk) begin
    if (rst) begin
      mix_sample  <= '0;
      mix_valid   <= 1'b0;
      buf_wr_en   <= 1'b0;
      buf_wr_addr <= '0;
      buf_wr_data <= '0;
      overrun     <= 1'b0;
      clip_count  <= '0;
      acc         <= '0;
      ch_idx      <= '0;
    end else begin
      mix_valid <= 1'b0;
      buf_wr_en <= 1'b0;
      if (buf_wr_en) buf_wr_addr <= buf_wr_addr + AB'(1);
      if (sample_tick && state != IDLE) overrun <= 1'b1;
      if (state == IDLE && sample_tick) begin
        smp_snap   <= ch_sample;
        vol_snap   <= ch_vol;
        mute_snap  <= ch_mute;
        atten_snap <= master_atten;
        acc        <= '0;
        ch_idx     <= '0;
      end
      if (state == ACCUM) begin
        acc    <= acc + term;
        ch_idx <= ch_idx + IW'(1);
      end
      if (state == SCALE) begin
        mix_sample  <= sat;
        buf_wr_data <= sat;
        mix_valid   <= 1'b1;
        buf_wr_en   <= 1'b1;
        if (clip && ~&clip_count) clip_count <= clip_count + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_audio_mixer_nch.sv
// tb_audio_mixer_nch: directed vectors with hand-computed results for the 4-channel mixer
module tb_audio_mixer_nch;
  logic        mclk = 1'b0;
  logic        rst, sample_tick;
  logic [63:0] ch_sample;
  logic [31:0] ch_vol;
  logic [3:0]  ch_mute, master_atten;
  logic        busy, mix_valid, buf_wr_en, overrun;
  logic [15:0] mix_sample, buf_wr_data, clip_count;
  logic [7:0]  buf_wr_addr;
  int errors = 0, checks = 0, exp_addr = 0;

  audio_mixer_nch dut (
    .mclk(mclk), .rst(rst), .sample_tick(sample_tick), .ch_sample(ch_sample),
    .ch_vol(ch_vol), .ch_mute(ch_mute), .master_atten(master_atten), .busy(busy),
    .mix_sample(mix_sample), .mix_valid(mix_valid), .buf_wr_en(buf_wr_en),
    .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data), .overrun(overrun),
    .clip_count(clip_count)
  );

  always #5 mclk = ~mclk;

  task automatic check(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic set_ch(input int i, input int smp, input int vol, input bit mute);
    ch_sample[i*16 +: 16] = smp[15:0];
    ch_vol[i*8 +: 8]      = vol[7:0];
    ch_mute[i]            = mute;
  endtask

  task automatic mute_all();
    for (int i = 0; i < 4; i++) set_ch(i, 0, 0, 1'b1);
  endtask

  // tick in cycle 0, result expected in cycle 6; optionally disturb inputs mid-mix
  task automatic run_mix(input string tag, input int want, input bit scramble);
    logic [63:0] s_smp;
    logic [3:0]  s_mute, s_att;
    int cyc;
    s_smp = ch_sample; s_mute = ch_mute; s_att = master_atten;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    if (scramble) begin
      ch_sample = ~ch_sample; ch_mute = '0; master_atten = 4'd0;
    end
    cyc = 1;
    while (!mix_valid && cyc < 20) begin
      step();
      cyc++;
    end
    check({tag, " latency"}, cyc, 6);
    check({tag, " sample"}, $signed(mix_sample), want);
    check({tag, " wr_data"}, $signed(buf_wr_data), want);
    check({tag, " wr_en"}, int'(buf_wr_en), 1);
    check({tag, " wr_addr"}, int'(buf_wr_addr), exp_addr % 256);
    exp_addr++;
    ch_sample = s_smp; ch_mute = s_mute; master_atten = s_att;
    step();
  endtask

  initial begin
    int vcount, vfirst, vlast;
    rst = 1'b1; sample_tick = 1'b0; ch_sample = '0; ch_vol = '0; ch_mute = '0; master_atten = '0;
    step(); step();
    rst = 1'b0;
    check("rst busy", int'(busy), 0);
    check("rst sample", int'(mix_sample), 0);
    check("rst valid", int'(mix_valid), 0);
    check("rst wr_en", int'(buf_wr_en), 0);
    check("rst addr", int'(buf_wr_addr), 0);
    check("rst wr_data", int'(buf_wr_data), 0);
    check("rst overrun", int'(overrun), 0);
    check("rst clip", int'(clip_count), 0);

    mute_all(); set_ch(0, 1000, 255, 1'b0);
    run_mix("pos1000", 996, 1'b0);
    set_ch(0, -1000, 255, 1'b0);
    run_mix("neg1000", -997, 1'b0);
    set_ch(0, -3, 255, 1'b0);
    run_mix("neg3", -3, 1'b0);
    for (int i = 0; i < 4; i++) set_ch(i, 32767, 255, 1'b0);
    run_mix("satpos", 32767, 1'b0);
    check("clip1", int'(clip_count), 1);
    for (int i = 0; i < 4; i++) set_ch(i, -32768, 255, 1'b0);
    run_mix("satneg", -32768, 1'b0);
    check("clip2", int'(clip_count), 2);
    set_ch(0, 1000, 128, 1'b0); set_ch(1, 2000, 128, 1'b0);
    set_ch(2, -500, 128, 1'b0); set_ch(3, 300, 128, 1'b0);
    master_atten = 4'd1;
    run_mix("sum4", 700, 1'b0);
    mute_all(); set_ch(0, 16384, 128, 1'b0); master_atten = 4'd2;
    run_mix("atten2 snap", 2048, 1'b1);
    check("clip held", int'(clip_count), 2);
    set_ch(0, 16384, 128, 1'b1);
    run_mix("muted", 0, 1'b0);
    set_ch(0, 16384, 0, 1'b0);
    run_mix("vol0", 0, 1'b0);
    check("no overrun yet", int'(overrun), 0);

    vcount = 0; vfirst = -1; vlast = -1;
    set_ch(0, 1000, 255, 1'b0); master_atten = 4'd0;
    for (int c = 0; c <= 12; c++) begin
      if (mix_valid) begin
        vcount++;
        if (vfirst < 0) vfirst = c;
        vlast = c;
      end
      if (c == 4) check("busy mid", int'(busy), 1);
      sample_tick = (c == 0 || c == 3 || c == 6);
      step();
    end
    sample_tick = 1'b0;
    check("ovr writes", vcount, 2);
    check("ovr first", vfirst, 6);
    check("ovr second", vlast, 12);
    check("overrun sticky", int'(overrun), 1);
    check("ovr addr", int'(buf_wr_addr), (exp_addr + 2) % 256);

    rst = 1'b1; step(); rst = 1'b0;
    check("rst2 overrun", int'(overrun), 0);
    check("rst2 addr", int'(buf_wr_addr), 0);
    check("rst2 clip", int'(clip_count), 0);
    exp_addr = 0;
    mute_all();
    for (int n = 0; n < 257; n++) run_mix("wrap", 0, 1'b0);
    check("wrap final", int'(buf_wr_addr), 1);

    set_ch(0, 1000, 255, 1'b0);
    sample_tick = 1'b1; step(); sample_tick = 1'b0;
    step();
    check("accum busy", int'(busy), 1);
    rst = 1'b1; step(); rst = 1'b0;
    vcount = 0;
    for (int c = 0; c < 10; c++) begin
      if (mix_valid || buf_wr_en) vcount++;
      step();
    end
    check("abort no write", vcount, 0);
    check("abort addr", int'(buf_wr_addr), 0);
    check("abort busy", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
